// File: rtl/bp_mon_pkg.sv
// bp_mon_pkg: shared types, default parameters and helpers for the branch-prediction event monitor
// Contents: burst FSM state enum, default parameter constants, saturating increment.
package bp_mon_pkg;
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WINDOW_RUN = 2'd1,
        ALARM      = 2'd2
    } bp_burst_state_t;

    localparam int DEF_CNT_W        = 32;
    localparam int DEF_TRACE_DEPTH  = 4;
    localparam int DEF_BURST_THRESH = 3;
    localparam int DEF_WINDOW       = 16;

    // Increment a value of width w (<= 64), holding at all-ones instead of wrapping.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
        logic [63:0] m;
        m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v == m) ? v : v + 64'd1;
    endfunction
endpackage

// File: rtl/bp_event_monitor_if.sv
// bp_event_monitor_if: debug-port and trace-stream signals between the core side and the monitor
// master: drives enable/clear/debug_*/trace_ready, observes counters and trace outputs.
// slave:  the monitor; samples the debug inputs, drives counters, trace head and flags.
interface bp_event_monitor_if
    import bp_mon_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             enable;
    logic             clear;
    logic [31:0]      debug_pc;
    logic             debug_misprediction;
    logic             debug_jump;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] jump_count;
    logic [CNT_W-1:0] mispredict_count;
    logic             trace_valid;
    logic             trace_ready;
    logic [31:0]      trace_pc;
    logic             trace_overflow;
    logic             burst_alarm;

    modport master (
        output enable, clear, debug_pc, debug_misprediction, debug_jump, trace_ready,
        input  cycle_count, jump_count, mispredict_count, trace_valid, trace_pc,
               trace_overflow, burst_alarm
    );

    modport slave (
        input  enable, clear, debug_pc, debug_misprediction, debug_jump, trace_ready,
        output cycle_count, jump_count, mispredict_count, trace_valid, trace_pc,
               trace_overflow, burst_alarm
    );
endinterface

// File: rtl/bp_trace_fifo.sv
// bp_trace_fifo: synchronous FIFO with registered storage and a combinational head read
// Ports: i_clock, i_reset (async, high), i_clear (sync), i_push/i_data, i_pop,
//        o_full, o_empty, o_head (entry at the read pointer).
module bp_trace_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_clear,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic         o_full,
    output logic         o_empty,
    output logic [W-1:0] o_head
);
    localparam int AW = $clog2(DEPTH);

    // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
    logic [AW:0]  r_wr;
    logic [AW:0]  r_rd;
    logic [W-1:0] r_mem [DEPTH];
    logic         w_do_push;
    logic         w_do_pop;

    assign o_empty   = r_wr == r_rd;
    assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign o_head    = r_mem[r_rd[AW-1:0]];
    assign w_do_pop  = i_pop && !o_empty;
    // A pop frees the slot this same edge, so a full FIFO can still accept the push.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_wr <= '0;
            r_rd <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_clear) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr[AW-1:0]] <= i_data;
                r_wr                <= r_wr + 1'b1;
            end
            if (w_do_pop) r_rd <= r_rd + 1'b1;
        end
    end
endmodule

// File: rtl/bp_event_monitor.sv
// bp_event_monitor: passive observer of the core's branch-prediction debug port
// Ports: clock, reset (async, high), bus (slave modport): enable/clear/debug_* in,
//        saturating cycle/jump/mispredict counters, mispredict-PC trace stream,
//        sticky trace_overflow and burst_alarm out.
module bp_event_monitor
    import bp_mon_pkg::*;
#(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int TRACE_DEPTH  = DEF_TRACE_DEPTH,
    parameter int BURST_THRESH = DEF_BURST_THRESH,
    parameter int WINDOW       = DEF_WINDOW
) (
    input logic              clock,
    input logic              reset,
    bp_event_monitor_if.slave bus
);
    localparam int HW = $clog2(BURST_THRESH + 1);
    localparam int TW = $clog2(WINDOW);

    logic [CNT_W-1:0] r_cyc;
    logic [CNT_W-1:0] r_jmp;
    logic [CNT_W-1:0] r_mis;
    logic             r_ovf;
    bp_burst_state_t  r_state;
    logic [HW-1:0]    r_hits;
    logic [TW-1:0]    r_timer;
    bp_burst_state_t  w_state;
    logic [HW-1:0]    w_hits;
    logic [TW-1:0]    w_timer;
    logic [HW-1:0]    w_hsum;
    logic             w_en;
    logic             w_mis;
    logic             w_jmp;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;

    // Clear outranks events, so a clearing cycle is never an enabled one.
    assign w_en   = bus.enable && !bus.clear;
    assign w_mis  = w_en && bus.debug_misprediction;
    assign w_jmp  = w_en && bus.debug_jump;
    assign w_pop  = !w_empty && bus.trace_ready;
    assign w_hsum = r_hits + HW'(w_mis);

    bp_trace_fifo #(.W(32), .DEPTH(TRACE_DEPTH)) u_fifo (
        .i_clock (clock),
        .i_reset (reset),
        .i_clear (bus.clear),
        .i_push  (w_mis),
        .i_data  (bus.debug_pc),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (bus.trace_pc)
    );

    // A mispredict on the expiring cycle still counts before expiry is taken.
    always_comb begin
        w_state = r_state;
        w_hits  = r_hits;
        w_timer = r_timer;
        if (w_mis && r_state == IDLE) begin
            w_state = WINDOW_RUN;
            w_hits  = HW'(1);
            w_timer = TW'(WINDOW - 1);
        end else if (w_en && r_state == WINDOW_RUN) begin
            if (w_hsum == HW'(BURST_THRESH)) begin
                w_state = ALARM;
            end else if (r_timer == '0) begin
                w_state = IDLE;
                w_hits  = '0;
            end else begin
                w_timer = r_timer - 1'b1;
                w_hits  = w_hsum;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cyc   <= '0;
            r_jmp   <= '0;
            r_mis   <= '0;
            r_ovf   <= 1'b0;
            r_state <= IDLE;
            r_hits  <= '0;
            r_timer <= '0;
        end else if (bus.clear) begin
            r_cyc   <= '0;
            r_jmp   <= '0;
            r_mis   <= '0;
            r_ovf   <= 1'b0;
            r_state <= IDLE;
            r_hits  <= '0;
            r_timer <= '0;
        end else begin
            if (w_en) r_cyc <= CNT_W'(sat_inc(64'(r_cyc), CNT_W));
            if (w_jmp) r_jmp <= CNT_W'(sat_inc(64'(r_jmp), CNT_W));
            if (w_mis) r_mis <= CNT_W'(sat_inc(64'(r_mis), CNT_W));
            if (w_mis && w_full && !w_pop) r_ovf <= 1'b1;
            r_state <= w_state;
            r_hits  <= w_hits;
            r_timer <= w_timer;
        end
    end

    assign bus.cycle_count      = r_cyc;
    assign bus.jump_count       = r_jmp;
    assign bus.mispredict_count = r_mis;
    assign bus.trace_valid      = !w_empty;
    assign bus.trace_overflow   = r_ovf;
    assign bus.burst_alarm      = r_state == ALARM;
endmodule
